// File: rtl/clkmon_supervisor.sv
// clkmon_supervisor: qualifies the clkmon tst_ok flag into a lock/loss controller.
// A tested clock is declared locked only after tst_ok has been continuously high for
// LOCK_CYC cycles; each loss forces a HOLD_CYC hold-off before relocking can begin.
// All outputs are registered and are cleared asynchronously by rst_n.
module clkmon_supervisor #(
   parameter int CLK_MHZ = 100,
   parameter int LOCK_US = 10,
   parameter int HOLD_US = 100,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tst_ok,
   input  logic             clr,
   output logic             locked,
   output logic             use_tst,
   output logic             lock_pulse,
   output logic             lost_pulse,
   output logic             sticky_lost,
   output logic [CNT_W-1:0] loss_cnt
);

   localparam int LOCK_CYC = CLK_MHZ * LOCK_US;
   localparam int HOLD_CYC = CLK_MHZ * HOLD_US;
   localparam int MAX_CYC  = (LOCK_CYC > HOLD_CYC) ? LOCK_CYC : HOLD_CYC;
   localparam int TIM_W    = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

   localparam logic [TIM_W-1:0] LOCK_END = TIM_W'(LOCK_CYC - 1);
   localparam logic [TIM_W-1:0] HOLD_END = TIM_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LOCKING = 2'd1;
   localparam logic [1:0] OK      = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   // A zero-length lock or hold window has no meaningful behaviour.
   generate
      if (LOCK_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
         $error("clkmon_supervisor: LOCK_CYC and HOLD_CYC must both be at least 1");
      end
   endgenerate

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [TIM_W-1:0] timer;
   logic [TIM_W-1:0] timer_nxt;
   logic             lock_ev;
   logic             loss_ev;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sticky_nxt;

   // Next-state and timer decode; the timer is zeroed on every state entry.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      lock_ev   = 1'b0;
      loss_ev   = 1'b0;
      case (state)
         IDLE: begin
            if (tst_ok) begin
               state_nxt = LOCKING;
               timer_nxt = '0;
            end
         end
         LOCKING: begin
            if (!tst_ok) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (timer == LOCK_END) begin
               state_nxt = OK;
               timer_nxt = '0;
               lock_ev   = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         OK: begin
            if (!tst_ok) begin
               state_nxt = HOLD;
               timer_nxt = '0;
               loss_ev   = 1'b1;
            end
         end
         HOLD: begin
            // tst_ok is deliberately ignored until the hold-off expires.
            if (timer == HOLD_END) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   // Loss bookkeeping: a clear takes effect first, then a same-edge loss is counted.
   always_comb begin
      cnt_base   = clr ? '0 : loss_cnt;
      sticky_nxt = clr ? 1'b0 : sticky_lost;
      cnt_nxt    = cnt_base;
      if (loss_ev) begin
         sticky_nxt = 1'b1;
         if (cnt_base != CNT_MAX) begin
            cnt_nxt = cnt_base + CNT_W'(1);
         end
      end
   end

   // State and timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Registered outputs, updated on the same edge as the state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked      <= 1'b0;
         lock_pulse  <= 1'b0;
         lost_pulse  <= 1'b0;
         sticky_lost <= 1'b0;
         loss_cnt    <= '0;
      end else begin
         locked      <= (state_nxt == OK);
         lock_pulse  <= lock_ev;
         lost_pulse  <= loss_ev;
         sticky_lost <= sticky_nxt;
         loss_cnt    <= cnt_nxt;
      end
   end

   // The mux select simply follows the lock status.
   assign use_tst = locked;

endmodule

// File: tb/tb_clkmon_supervisor.sv
// Bench for clkmon_supervisor: directed scenarios with literal expectations plus a
// run-length model of the lock/hold rules checked against the DUT every cycle.
module tb_clkmon_supervisor;

   localparam int CLK_MHZ  = 100;
   localparam int LOCK_US  = 10;
   localparam int HOLD_US  = 2;
   localparam int CNT_W    = 2;
   localparam int LOCK_CYC = CLK_MHZ * LOCK_US;
   localparam int HOLD_CYC = CLK_MHZ * HOLD_US;
   localparam int CNT_TOP  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tst_ok;
   logic             clr;
   logic             locked;
   logic             use_tst;
   logic             lock_pulse;
   logic             lost_pulse;
   logic             sticky_lost;
   logic [CNT_W-1:0] loss_cnt;

   int total = 0;
   int bad   = 0;

   clkmon_supervisor #(
      .CLK_MHZ(CLK_MHZ),
      .LOCK_US(LOCK_US),
      .HOLD_US(HOLD_US),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tst_ok     (tst_ok),
      .clr        (clr),
      .locked     (locked),
      .use_tst    (use_tst),
      .lock_pulse (lock_pulse),
      .lost_pulse (lost_pulse),
      .sticky_lost(sticky_lost),
      .loss_cnt   (loss_cnt)
   );

   always #5 clk = ~clk;

   // Model: lock after LOCK_CYC+1 consecutive high samples outside hold-off;
   // a loss starts a hold-off of HOLD_CYC edges during which tst_ok is ignored.
   int run       = 0;
   int hold_left = 0;
   bit m_locked  = 1'b0;
   bit m_lockp   = 1'b0;
   bit m_lostp   = 1'b0;
   bit m_sticky  = 1'b0;
   int m_cnt     = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run = 0; hold_left = 0; m_locked = 0; m_lockp = 0;
         m_lostp = 0; m_sticky = 0; m_cnt = 0;
      end else begin
         m_lockp = 0;
         m_lostp = 0;
         if (clr) begin
            m_cnt = 0;
            m_sticky = 0;
         end
         if (m_locked) begin
            if (!tst_ok) begin
               m_locked = 0;
               m_lostp = 1;
               hold_left = HOLD_CYC;
               m_sticky = 1;
               if (m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
            end
         end else if (hold_left > 0) begin
            hold_left = hold_left - 1;
         end else if (tst_ok) begin
            run = run + 1;
            if (run == LOCK_CYC + 1) begin
               m_locked = 1;
               m_lockp = 1;
               run = 0;
            end
         end else begin
            run = 0;
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [6:0] act_v;
      logic [6:0] exp_v;
      act_v = {locked, use_tst, lock_pulse, lost_pulse, sticky_lost, loss_cnt};
      exp_v = {m_locked, m_locked, m_lockp, m_lostp, m_sticky, CNT_W'(m_cnt)};
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL model_cmp: got %b expected %b at %0t", act_v, exp_v, $time);
      end
   end

   // Counts negedges until locked is seen, bounded.
   task automatic wait_lock(input string nm, input int exp_n);
      int n;
      n = 0;
      while (locked !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(nm, n, exp_n);
   endtask

   task automatic check_all_zero(input string nm);
      check(nm, int'({locked, use_tst, lock_pulse, lost_pulse, sticky_lost, loss_cnt}), 0);
   endtask

   initial begin
      int exp_cnt[4];
      exp_cnt = '{1, 2, 3, 3};
      rst_n  = 1'b0;
      tst_ok = 1'b0;
      clr    = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");

      // Scenario 1: release reset with tst_ok held high.
      rst_n  = 1'b1;
      tst_ok = 1'b1;
      wait_lock("sc1_lock_latency", LOCK_CYC + 1);
      check("sc1_lock_pulse", int'(lock_pulse), 1);
      check("sc1_use_tst", int'(use_tst), 1);
      @(negedge clk);
      check("sc1_lock_pulse_gone", int'(lock_pulse), 0);
      check("sc1_cnt", int'(loss_cnt), 0);
      check("sc1_sticky", int'(sticky_lost), 0);

      // Scenario 3: one-cycle drop from OK.
      tst_ok = 1'b0;
      @(negedge clk);
      tst_ok = 1'b1;
      check("sc3_lost_pulse", int'(lost_pulse), 1);
      check("sc3_locked", int'(locked), 0);
      check("sc3_sticky", int'(sticky_lost), 1);
      check("sc3_cnt", int'(loss_cnt), 1);
      wait_lock("sc3_relock_latency", HOLD_CYC + 1 + LOCK_CYC);

      // Scenario 2: abort LOCKING at timer=500 and restart.
      tst_ok = 1'b0;
      repeat (300) @(negedge clk);
      tst_ok = 1'b1;
      repeat (501) @(negedge clk);
      tst_ok = 1'b0;
      @(negedge clk);
      check("sc2_not_locked", int'(locked), 0);
      tst_ok = 1'b1;
      wait_lock("sc2_restart_latency", LOCK_CYC + 1);
      check("sc2_cnt", int'(loss_cnt), 2);

      // Scenario 4: clear, then four loss/relock cycles saturating the counter.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("sc4_clr_cnt", int'(loss_cnt), 0);
      check("sc4_clr_sticky", int'(sticky_lost), 0);
      check("sc4_clr_locked", int'(locked), 1);
      for (int i = 0; i < 4; i++) begin
         tst_ok = 1'b0;
         @(negedge clk);
         tst_ok = 1'b1;
         check($sformatf("sc4_cnt_%0d", i), int'(loss_cnt), exp_cnt[i]);
         wait_lock($sformatf("sc4_relock_%0d", i), HOLD_CYC + 1 + LOCK_CYC);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("sc4_clr2_cnt", int'(loss_cnt), 0);
      check("sc4_clr2_sticky", int'(sticky_lost), 0);
      check("sc4_clr2_locked", int'(locked), 1);

      // Scenario 5: clear coinciding with a loss edge.
      tst_ok = 1'b0;
      @(negedge clk);
      tst_ok = 1'b1;
      check("sc5_pre_cnt", int'(loss_cnt), 1);
      wait_lock("sc5_pre_relock", HOLD_CYC + 1 + LOCK_CYC);
      tst_ok = 1'b0;
      clr    = 1'b1;
      @(negedge clk);
      tst_ok = 1'b1;
      clr    = 1'b0;
      check("sc5_cnt", int'(loss_cnt), 1);
      check("sc5_sticky", int'(sticky_lost), 1);
      check("sc5_lost_pulse", int'(lost_pulse), 1);
      wait_lock("sc5_relock", HOLD_CYC + 1 + LOCK_CYC);

      // Scenario 6a: asynchronous reset mid-OK.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("sc6_async_ok");
      @(negedge clk);
      rst_n = 1'b1;
      wait_lock("sc6_relock_after_ok", LOCK_CYC + 1);

      // Scenario 6b: asynchronous reset mid-HOLD.
      tst_ok = 1'b0;
      @(negedge clk);
      tst_ok = 1'b1;
      repeat (50) @(negedge clk);
      check("sc6_in_hold", int'(locked), 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("sc6_async_hold");
      @(negedge clk);
      rst_n = 1'b1;
      wait_lock("sc6_relock_after_hold", LOCK_CYC + 1);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
